// File: rtl/vec_issue_sequencer.sv
// -----------------------------------------------------------------------------
// vec_issue_sequencer
//
// Issue sequencer between the scalar core and the vector processor. Scalar
// instruction/rs1/rs2 triples are queued in a DEPTH-entry circular FIFO and
// issued one at a time when the vector processor is ready. An issued
// instruction is held stable on the outputs until it is acknowledged. Illegal
// instructions and acknowledge timeouts are retired with one-cycle status
// pulses.
//
// Parameters
//   XLEN     instruction / operand width
//   DEPTH    FIFO entries (power of 2, >= 2)
//   TIMEOUT  maximum WAIT_ACK cycles before the instruction is aborted (>= 1)
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   flush               synchronous clear of FIFO, FSM, outputs and pulses
//   sp_valid/sp_ready   scalar-side push handshake
//   sp_inst/rs1/rs2     scalar-side entry fields
//   instruction,
//   rs1_data, rs2_data  registered entry presented to the vector processor
//   vp_inst_valid       high while in ISSUE or WAIT_ACK
//   vec_pro_ready       vector processor can accept an instruction
//   is_vec              combinational legality of `instruction`
//   vec_pro_ack         current instruction completed
//   inst_done           one-cycle retire pulse
//   illegal_inst        one-cycle pulse, illegal instruction dropped
//   ack_timeout         one-cycle pulse, acknowledge timed out
//   fifo_count          FIFO occupancy
//   busy                FSM not idle or FIFO not empty
// -----------------------------------------------------------------------------
module vec_issue_sequencer #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     sp_valid,
   output logic                     sp_ready,
   input  logic [XLEN-1:0]          sp_inst,
   input  logic [XLEN-1:0]          sp_rs1,
   input  logic [XLEN-1:0]          sp_rs2,
   output logic [XLEN-1:0]          instruction,
   output logic [XLEN-1:0]          rs1_data,
   output logic [XLEN-1:0]          rs2_data,
   output logic                     vp_inst_valid,
   input  logic                     vec_pro_ready,
   input  logic                     is_vec,
   input  logic                     vec_pro_ack,
   output logic                     inst_done,
   output logic                     illegal_inst,
   output logic                     ack_timeout,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned EW = 3 * XLEN;

   localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
   localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_ACK = 2'd2
   } state_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e          state_q,    state_d;
   logic [AW-1:0]   wr_ptr_q,   wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q,   rd_ptr_d;
   logic [CW-1:0]   count_q,    count_d;
   logic [TW-1:0]   wait_cnt_q, wait_cnt_d;
   logic [XLEN-1:0] inst_q,     inst_d;
   logic [XLEN-1:0] rs1_q,      rs1_d;
   logic [XLEN-1:0] rs2_q,      rs2_d;
   logic            done_q,     done_d;
   logic            illegal_q,  illegal_d;
   logic            timeout_q,  timeout_d;

   logic [EW-1:0]   mem_q [DEPTH];
   logic [EW-1:0]   head;
   logic            push;
   logic            pop;

   // Ready comes from the registered count only; a pop in the same cycle does
   // not open a slot until the following cycle.
   assign sp_ready = (count_q != COUNT_FULL);
   assign push     = sp_valid && sp_ready && !flush;
   assign head     = mem_q[rd_ptr_q];

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every variable gets a default at the top of the block so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      inst_d     = inst_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      done_d     = 1'b0;
      illegal_d  = 1'b0;
      timeout_d  = 1'b0;
      pop        = 1'b0;

      unique case (state_q)
         IDLE: begin
            inst_d = '0;
            rs1_d  = '0;
            rs2_d  = '0;
            if ((count_q != '0) && vec_pro_ready) begin
               pop                   = 1'b1;
               {inst_d, rs1_d, rs2_d} = head;
               state_d               = ISSUE;
            end
         end

         ISSUE: begin
            if (!is_vec) begin
               state_d   = IDLE;
               illegal_d = 1'b1;
            end else if (vec_pro_ack) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               state_d    = WAIT_ACK;
               wait_cnt_d = '0;
            end
         end

         WAIT_ACK: begin
            // Acknowledge wins over a timeout landing in the same cycle.
            if (vec_pro_ack) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase

      // Leaving for IDLE clears the presented entry on the same edge.
      if ((state_q != IDLE) && (state_d == IDLE)) begin
         inst_d = '0;
         rs1_d  = '0;
         rs2_d  = '0;
      end

      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // Flush discards everything, including an in-flight instruction and any
      // pulse that would have been raised on this edge.
      if (flush) begin
         state_d    = IDLE;
         wait_cnt_d = '0;
         inst_d     = '0;
         rs1_d      = '0;
         rs2_d      = '0;
         done_d     = 1'b0;
         illegal_d  = 1'b0;
         timeout_d  = 1'b0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         wait_cnt_q <= '0;
         inst_q     <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         done_q     <= 1'b0;
         illegal_q  <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         wait_cnt_q <= wait_cnt_d;
         inst_q     <= inst_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         done_q     <= done_d;
         illegal_q  <= illegal_d;
         timeout_q  <= timeout_d;
      end
   end

   // NOTE: the storage array is not reset; an entry is only read after it has
   // been written, and the occupancy count guards every read.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         mem_q[wr_ptr_q] <= {sp_inst, sp_rs1, sp_rs2};
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign instruction   = inst_q;
   assign rs1_data      = rs1_q;
   assign rs2_data      = rs2_q;
   assign vp_inst_valid = (state_q == ISSUE) || (state_q == WAIT_ACK);
   assign inst_done     = done_q;
   assign illegal_inst  = illegal_q;
   assign ack_timeout   = timeout_q;
   assign fifo_count    = count_q;
   assign busy          = (state_q != IDLE) || (count_q != '0);

endmodule
